// File: rtl/bus_interval_timer_pkg.sv
// Shared constants for the bus interval timer: register offsets, bit indices
// and the bus handshake state type.
package timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_AUTO      = 1;
    localparam int STATUS_TIMEOUT = 0;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_RESP = 1'b1
    } bus_state_e;

endpackage

// File: rtl/bus_interval_timer_tick_gen.sv
// Prescaler: counts PRESCALE-1 down to 0 while enabled and flags a tick at 0.
module tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] RELOAD = W'(PRESCALE - 1);

    logic [W-1:0] presc_q, presc_d;

    always_comb begin
        presc_d = presc_q;
        if (restart) begin
            presc_d = RELOAD;
        end else if (en) begin
            presc_d = (presc_q == '0) ? RELOAD : presc_q - 1'b1;
        end
    end

    // The tick stays valid on a restart edge; the consumer decides priority.
    assign tick = en && (presc_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc_q <= RELOAD;
        else     presc_q <= presc_d;
    end

endmodule

// File: rtl/bus_interval_timer.sv
// Memory-mapped interval timer: bus handshake FSM, CTRL/PERIOD/COUNT/STATUS
// registers and the tick-driven COUNT/TIMEOUT logic.
//
// state    | meaning
// BUS_IDLE | waiting for a strobe that hits the register window
// BUS_RESP | DataDone cycle; strobes are ignored
module bus_interval_timer
    import timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hA000,
    parameter int          PRESCALE  = 50000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReadData,
    input  logic        WriteData,
    input  logic [15:0] DataAddr,
    input  logic [15:0] DataOut,
    output logic [15:0] DataIn,
    output logic        DataDone,
    output logic        TimeoutLed
);

    bus_state_e  state_q, state_d;
    logic [15:0] data_in_q, data_in_d;
    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic [15:0] period_q, period_d;
    logic [15:0] count_q, count_d;
    logic        timeout_q, timeout_d;

    logic        hit, accept, wr, rd;
    logic        wr_ctrl, wr_period, wr_status;
    logic        tick, tick_ok, restart;
    logic [15:0] rdata;

    always_comb begin
        hit       = (DataAddr[15:2] == BASE_ADDR[15:2]);
        accept    = (ReadData || WriteData) && hit && (state_q == BUS_IDLE);
        wr        = accept && WriteData;
        rd        = accept && !WriteData;
        wr_ctrl   = wr && (DataAddr[1:0] == REG_CTRL);
        wr_period = wr && (DataAddr[1:0] == REG_PERIOD);
        wr_status = wr && (DataAddr[1:0] == REG_STATUS);
        // Disabling on a tick edge discards that tick entirely.
        tick_ok   = tick && !(wr_ctrl && !DataOut[CTRL_EN]);
        restart   = wr_period || (wr_ctrl && DataOut[CTRL_EN] && !en_q);
    end

    always_comb begin
        rdata = 16'h0000;
        case (DataAddr[1:0])
            REG_CTRL:   rdata = {14'h0000, auto_q, en_q};
            REG_PERIOD: rdata = period_q;
            REG_COUNT:  rdata = count_q;
            REG_STATUS: rdata = {15'h0000, timeout_q};
            default:    rdata = 16'h0000;
        endcase
    end

    always_comb begin
        state_d   = accept ? BUS_RESP : BUS_IDLE;
        data_in_d = rd ? rdata : 16'h0000;
    end

    always_comb begin
        en_d      = en_q;
        auto_d    = auto_q;
        period_d  = period_q;
        count_d   = count_q;
        timeout_d = timeout_q;

        if (wr_status && DataOut[STATUS_TIMEOUT]) timeout_d = 1'b0;

        if (tick_ok) begin
            if (count_q != 16'h0000) begin
                count_d = count_q - 16'd1;
            end else begin
                timeout_d = 1'b1;
                if (auto_q) count_d = period_q;
                else        en_d    = 1'b0;
            end
        end

        // Bus writes override whatever the tick did on the same edge.
        if (wr_ctrl) begin
            en_d   = DataOut[CTRL_EN];
            auto_d = DataOut[CTRL_AUTO];
        end
        if (wr_period) begin
            period_d = DataOut;
            count_d  = DataOut;
        end
    end

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk     (Clock),
        .rst     (Reset),
        .en      (en_q),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= BUS_IDLE;
            data_in_q <= 16'h0000;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            period_q  <= 16'h0000;
            count_q   <= 16'h0000;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_in_q <= data_in_d;
            en_q      <= en_d;
            auto_q    <= auto_d;
            period_q  <= period_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign DataIn     = data_in_q;
    assign DataDone   = (state_q == BUS_RESP);
    assign TimeoutLed = timeout_q;

endmodule

// File: tb/tb_bus_interval_timer.sv
// Directed bench for bus_interval_timer with PRESCALE=4: register table plus
// hand-written timing sequences for countdown, auto-reload and reset.
module tb_bus_interval_timer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        ReadData = 1'b0;
    logic        WriteData = 1'b0;
    logic [15:0] DataAddr = 16'h0000;
    logic [15:0] DataOut = 16'h0000;
    logic [15:0] DataIn;
    logic        DataDone;
    logic        TimeoutLed;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bus_interval_timer #(.BASE_ADDR(16'hA000), .PRESCALE(4)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .ReadData   (ReadData),
        .WriteData  (WriteData),
        .DataAddr   (DataAddr),
        .DataOut    (DataOut),
        .DataIn     (DataIn),
        .DataDone   (DataDone),
        .TimeoutLed (TimeoutLed)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic        exp_done;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1 outside a DataDone cycle; returns likewise.
    task automatic access(input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, output logic dn, output logic [15:0] q);
        ReadData  = r;
        WriteData = w;
        DataAddr  = a;
        DataOut   = d;
        @(posedge Clock);
        #1;
        dn = DataDone;
        q  = DataIn;
        ReadData  = 1'b0;
        WriteData = 1'b0;
        @(posedge Clock);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
        logic dn;
        logic [15:0] q;
        access(1'b1, 1'b0, a, 16'h0000, dn, q);
        chk({name, "_done"}, {31'b0, dn}, 32'd1);
        chk(name, {16'b0, q}, {16'b0, exp});
    endtask

    task automatic wr_do(input string name, input logic [15:0] a, input logic [15:0] d);
        logic dn;
        logic [15:0] q;
        access(1'b0, 1'b1, a, d, dn, q);
        chk({name, "_done"}, {31'b0, dn}, 32'd1);
    endtask

    // Strobe is set now and accepted at the next edge; returns at edge+1.
    task automatic wr_inline(input logic [15:0] a, input logic [15:0] d);
        WriteData = 1'b1;
        DataAddr  = a;
        DataOut   = d;
        @(posedge Clock);
        #1;
        WriteData = 1'b0;
    endtask

    task automatic wait_led(input int limit);
        int n;
        n = 0;
        while (!TimeoutLed && n < limit) begin
            @(posedge Clock);
            #1;
            n++;
        end
    endtask

    initial begin
        int e;
        int pulses;
        logic dn;
        logic [15:0] q;

        vecs[0]  = '{1'b1, 1'b0, 16'hA000, 16'h0000, 1'b1, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 16'hA001, 16'h0000, 1'b1, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 16'hA002, 16'h0000, 1'b1, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 16'hA003, 16'h0000, 1'b1, 16'h0000};
        vecs[4]  = '{1'b1, 1'b1, 16'hA001, 16'h0005, 1'b1, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 16'hA001, 16'h0000, 1'b1, 16'h0005};
        vecs[6]  = '{1'b1, 1'b0, 16'hA002, 16'h0000, 1'b1, 16'h0005};
        vecs[7]  = '{1'b0, 1'b1, 16'hA002, 16'h0009, 1'b1, 16'h0000};
        vecs[8]  = '{1'b1, 1'b0, 16'hA002, 16'h0000, 1'b1, 16'h0005};
        vecs[9]  = '{1'b1, 1'b0, 16'hA004, 16'h0000, 1'b0, 16'h0000};
        vecs[10] = '{1'b0, 1'b1, 16'hA004, 16'h0003, 1'b0, 16'h0000};
        vecs[11] = '{1'b1, 1'b0, 16'hA000, 16'h0000, 1'b1, 16'h0000};
        vecs[12] = '{1'b0, 1'b1, 16'hB001, 16'h0077, 1'b0, 16'h0000};
        vecs[13] = '{1'b1, 1'b0, 16'hA001, 16'h0000, 1'b1, 16'h0005};
        vecs[14] = '{1'b0, 1'b1, 16'hA000, 16'hFFFE, 1'b1, 16'h0000};
        vecs[15] = '{1'b1, 1'b0, 16'hA000, 16'h0000, 1'b1, 16'h0002};
        vecs[16] = '{1'b0, 1'b1, 16'hA000, 16'h0000, 1'b1, 16'h0000};

        repeat (2) @(posedge Clock);
        #1;
        chk("rst_done", {31'b0, DataDone}, 32'd0);
        chk("rst_datain", {16'b0, DataIn}, 32'd0);
        chk("rst_led", {31'b0, TimeoutLed}, 32'd0);
        Reset = 1'b0;
        @(posedge Clock);
        #1;

        for (int i = 0; i < 17; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, dn, q);
            chk($sformatf("vec%0d_done", i), {31'b0, dn}, {31'b0, vecs[i].exp_done});
            chk($sformatf("vec%0d_data", i), {16'b0, q}, {16'b0, vecs[i].exp_data});
        end

        // One-shot: PERIOD=3, four ticks of four cycles each.
        wr_do("os_period", 16'hA001, 16'd3);
        wr_inline(16'hA000, 16'h0001);
        e = cyc;
        wait_led(100);
        chk("os_latency", cyc - e, 32'd16);
        rd_chk("os_count", 16'hA002, 16'h0000);
        rd_chk("os_ctrl", 16'hA000, 16'h0000);
        rd_chk("os_status", 16'hA003, 16'h0001);
        wr_do("os_wr0", 16'hA003, 16'h0000);
        chk("os_clr0_led", {31'b0, TimeoutLed}, 32'd1);
        wr_do("os_wr1", 16'hA003, 16'h0001);
        chk("os_clr1_led", {31'b0, TimeoutLed}, 32'd0);

        // Auto-reload: PERIOD=2 gives a terminal tick every 12 cycles.
        wr_do("ar_period", 16'hA001, 16'd2);
        wr_inline(16'hA000, 16'h0003);
        e = cyc;
        wait_led(100);
        chk("ar_first", cyc - e, 32'd12);
        wr_do("ar_clr_a", 16'hA003, 16'h0001);
        chk("ar_clr_a_led", {31'b0, TimeoutLed}, 32'd0);
        wait_led(100);
        chk("ar_second", cyc - e, 32'd24);
        wr_do("ar_clr_b", 16'hA003, 16'h0001);
        chk("ar_clr_b_led", {31'b0, TimeoutLed}, 32'd0);
        while (cyc - e < 35) begin
            @(posedge Clock);
            #1;
        end
        wr_inline(16'hA003, 16'h0001);
        chk("ar_setwins_edge", cyc - e, 32'd36);
        chk("ar_setwins_led", {31'b0, TimeoutLed}, 32'd1);
        @(posedge Clock);
        #1;
        wr_do("ar_stop", 16'hA000, 16'h0000);

        // Busy rule: a 4-cycle strobe yields two responses.
        pulses = 0;
        ReadData = 1'b1;
        DataAddr = 16'hA002;
        repeat (4) begin
            @(posedge Clock);
            #1;
            if (DataDone) pulses++;
        end
        ReadData = 1'b0;
        chk("busy_pulses", pulses, 32'd2);
        @(posedge Clock);
        #1;

        // Disable on a tick edge: only the first tick decrements.
        wr_do("dis_period", 16'hA001, 16'd5);
        wr_inline(16'hA000, 16'h0001);
        e = cyc;
        while (cyc - e < 7) begin
            @(posedge Clock);
            #1;
        end
        wr_inline(16'hA000, 16'h0000);
        @(posedge Clock);
        #1;
        rd_chk("dis_count", 16'hA002, 16'h0004);
        rd_chk("dis_ctrl", 16'hA000, 16'h0000);

        // Reset during the response cycle.
        wr_do("rr_ctrl", 16'hA000, 16'h0002);
        chk("rr_led_before", {31'b0, TimeoutLed}, 32'd1);
        ReadData = 1'b1;
        DataAddr = 16'hA001;
        @(posedge Clock);
        #1;
        ReadData = 1'b0;
        Reset = 1'b1;
        #1;
        chk("rr_done", {31'b0, DataDone}, 32'd0);
        chk("rr_led", {31'b0, TimeoutLed}, 32'd0);
        @(posedge Clock);
        #1;
        chk("rr_done_late", {31'b0, DataDone}, 32'd0);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        rd_chk("rr_ctrl_rd", 16'hA000, 16'h0000);
        rd_chk("rr_period_rd", 16'hA001, 16'h0000);
        rd_chk("rr_count_rd", 16'hA002, 16'h0000);
        rd_chk("rr_status_rd", 16'hA003, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
